// File: rtl/btn_nibble_ctrl_pkg.sv
// rtl/btn_nibble_ctrl_pkg.sv - shared debounce state encoding and default qualification time
package btn_nibble_ctrl_pkg;

  // 10 ms at 50 MHz
  localparam int DB_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    REL    = 2'd0,
    P_WAIT = 2'd1,
    PRS    = 2'd2,
    R_WAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/btn_nibble_ctrl_debounce.sv
// rtl/btn_nibble_ctrl_debounce.sv - two-flop synchronizer plus debounce FSM emitting a one-cycle press pulse
module btn_debounce
  import btn_nibble_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press
);

  // The qualifying edge is the one on which the counter would reach DB_CYCLES-1,
  // so the FSM sees DB_CYCLES consecutive synced samples of the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 2);

  logic [1:0]       sync_q, sync_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             btn_s;

  assign btn_s = sync_q[1];
  assign press = press_q;

  // Next-state logic: synchronizer shift, debounce transitions, counter and pulse
  always_comb begin
    sync_d  = {sync_q[0], btn_in};
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    unique case (state_q)
      REL: begin
        if (btn_s) state_d = P_WAIT;
      end
      P_WAIT: begin
        if (!btn_s) begin
          state_d = REL;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRS: begin
        if (!btn_s) state_d = R_WAIT;
      end
      R_WAIT: begin
        if (btn_s) begin
          state_d = PRS;
        end else if (cnt_q == CNT_LAST) begin
          state_d = REL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = REL;
    endcase
  end

  // State registers; reset drops everything back to released and idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= REL;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

endmodule

// File: rtl/btn_nibble_ctrl.sv
// rtl/btn_nibble_ctrl.sv - debounced press toggles nibble select and captures switches onto leds (option PRESS_CNT_EN adds press_cnt)
module btn_nibble_ctrl
  import btn_nibble_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic [7:0] switch,
`ifdef PRESS_CNT_EN
  output logic [7:0] press_cnt,
`endif
  output logic [7:0] led,
  output logic       sel,
  output logic       press
);

  logic [7:0] sw_s1_q, sw_s1_d;
  logic [7:0] sw_s2_q, sw_s2_d;
  logic [7:0] cap_q, cap_d;
  logic       sel_q, sel_d;
  logic [7:0] led_q, led_d;
  logic       press_w;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (button),
    .press  (press_w)
  );

  assign press = press_w;
  assign sel   = sel_q;
  assign led   = led_q;

  // Capture and toggle on the press cycle; led follows sel/cap one cycle later
  always_comb begin
    sw_s1_d = switch;
    sw_s2_d = sw_s1_q;
    cap_d   = press_w ? sw_s2_q : cap_q;
    sel_d   = press_w ? ~sel_q : sel_q;
    led_d   = sel_q ? {cap_q[7:4], 4'h0} : {4'h0, cap_q[3:0]};
  end

  // Switch synchronizer, captured value, select and led registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      cap_q   <= '0;
      sel_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      cap_q   <= cap_d;
      sel_q   <= sel_d;
      led_q   <= led_d;
    end
  end

`ifdef PRESS_CNT_EN
  logic [7:0] press_cnt_q, press_cnt_d;

  assign press_cnt = press_cnt_q;

  // Wrapping count of qualified presses
  always_comb begin
    press_cnt_d = press_w ? press_cnt_q + 8'd1 : press_cnt_q;
  end

  // Press counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) press_cnt_q <= '0;
    else        press_cnt_q <= press_cnt_d;
  end
`endif

endmodule

// File: tb/tb_btn_nibble_ctrl.sv
// tb/tb_btn_nibble_ctrl.sv - directed self-checking bench for btn_nibble_ctrl with DB_CYCLES=8 (option PRESS_CNT_EN)
module tb_btn_nibble_ctrl;

  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic [7:0] switch = 8'h00;
  logic [7:0] led;
  logic       sel;
  logic       press;
`ifdef PRESS_CNT_EN
  logic [7:0] press_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_press = 0;

  btn_nibble_ctrl #(
    .DB_CYCLES (DB),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .switch    (switch),
`ifdef PRESS_CNT_EN
    .press_cnt (press_cnt),
`endif
    .led       (led),
    .sel       (sel),
    .press     (press)
  );

  always #5 clk = ~clk;

  // Count press pulses seen while out of reset
  always @(negedge clk) begin
    if (rst_n && press) n_press++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the button long enough to qualify, then release long enough to re-arm
  task automatic full_press(input logic [7:0] sw);
    switch = sw;
    tick(4);
    button = 1'b1;
    tick(DB + 6);
    button = 1'b0;
    tick(DB + 6);
  endtask

  initial begin
    tick(3);
    chk("rst_led", {24'h0, led}, 32'h00);
    chk("rst_sel", {31'h0, sel}, 32'h0);
    chk("rst_press", {31'h0, press}, 32'h0);
    rst_n = 1'b1;
    switch = 8'hA5;
    tick(5);

    // First press: latency 2 + DB + 2 to led
    button = 1'b1;
    tick(DB + 1);
    chk("p1_press_early", {31'h0, press}, 32'h0);
    tick(1);
    chk("p1_press", {31'h0, press}, 32'h1);
    tick(1);
    chk("p1_press_gone", {31'h0, press}, 32'h0);
    chk("p1_sel", {31'h0, sel}, 32'h1);
    chk("p1_led_early", {24'h0, led}, 32'h00);
    tick(1);
    chk("p1_led", {24'h0, led}, 32'hA0);
    tick(20 - (DB + 4));
    chk("p1_npress", n_press, 1);

    // Release, then a second press with new switches
    button = 1'b0;
    tick(DB + 6);
    full_press(8'h3C);
    chk("p2_sel", {31'h0, sel}, 32'h0);
    chk("p2_led", {24'h0, led}, 32'h0C);
    chk("p2_npress", n_press, 2);

    // Bounce every 3 cycles: never qualifies
    for (int i = 0; i < 40; i++) begin
      button = ((i / 3) % 2) == 0;
      tick(1);
    end
    button = 1'b0;
    tick(DB + 6);
    chk("bnc_npress", n_press, 2);
    chk("bnc_sel", {31'h0, sel}, 32'h0);
    chk("bnc_led", {24'h0, led}, 32'h0C);

    // Switch change without a press leaves led alone
    full_press(8'hA5);
    chk("sw_led_pre", {24'h0, led}, 32'hA0);
    switch = 8'hFF;
    tick(20);
    chk("sw_led_hold", {24'h0, led}, 32'hA0);

    // Reset in P_WAIT with counter at 5
    button = 1'b1;
    tick(DB);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_led", {24'h0, led}, 32'h00);
    chk("mid_rst_sel", {31'h0, sel}, 32'h0);
    chk("mid_rst_press", {31'h0, press}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2 + DB - 1);
    chk("rel_press_early", {31'h0, press}, 32'h0);
    tick(1);
    chk("rel_press", {31'h0, press}, 32'h1);
    tick(1);
    chk("rel_sel", {31'h0, sel}, 32'h1);
    button = 1'b0;
    tick(DB + 6);

`ifdef PRESS_CNT_EN
    rst_n = 1'b0;
    tick(2);
    chk("cnt_rst", {24'h0, press_cnt}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 257; i++) full_press(8'h12);
    chk("cnt_wrap", {24'h0, press_cnt}, 32'h1);
    chk("cnt_sel", {31'h0, sel}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
